// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: a single full-adder cell is reused over WIDTH cycles.
// Operands are latched on start, and the result is published with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_overflow;
  logic             r_busy;
  logic             r_done;

  logic             w_bit;
  logic             w_carry_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  assign w_bit        = r_op_a[0] ^ r_op_b[0] ^ r_carry;
  assign w_carry_next = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);
  assign w_last       = (r_cnt == LAST_BIT);

  // Each new bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_res_single
      assign w_res_next = w_bit;
    end else begin : g_res_multi
      assign w_res_next = {w_bit, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_res      <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_carry <= w_carry_next;
          r_res   <= w_res_next;
          r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) begin
            // r_carry is still the carry into the MSB at this point.
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_sum      <= w_res_next;
            r_cout     <= w_carry_next;
            r_overflow <= r_carry ^ w_carry_next;
          end
        end
        default: begin
          // The done cycle also serves as the first idle cycle, so a held start
          // gives one operation every WIDTH+1 cycles.
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_cnt   <= '0;
            r_res   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_overflow;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=4 and WIDTH=1 instances, arithmetic
// reference model, per-cycle compare process, directed and random stimulus.
`timescale 1ns/1ps
module tb_serial_adder;

  localparam int NI = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_v [NI];
  logic       sub_v   [NI];
  logic       cin_v   [NI];
  logic [3:0] a_v     [NI];
  logic [3:0] b_v     [NI];

  logic [3:0] sum4;
  logic [0:0] sum1;
  logic [3:0] sum_o  [NI];
  logic       cout_o [NI];
  logic       ovf_o  [NI];
  logic       busy_o [NI];
  logic       done_o [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
    .sum(sum4), .cout(cout_o[0]), .overflow(ovf_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]),
    .a(a_v[1][0:0]), .b(b_v[1][0:0]), .cin(cin_v[1]),
    .sum(sum1), .cout(cout_o[1]), .overflow(ovf_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  always_comb begin
    sum_o[0] = sum4;
    sum_o[1] = {3'b000, sum1};
  end

  function automatic int wid(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Returns {overflow, cout, sum[3:0]} from plain integer arithmetic.
  function automatic logic [5:0] ref_op(input int w, input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic sub);
    int mask, ua, ub, sa, sb, u, s;
    logic [5:0] r;
    mask = (1 << w) - 1;
    ua = int'(a) & mask;
    ub = int'(b) & mask;
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    if (!sub) begin
      u = ua + ub + int'(cin);
      s = sa + sb + int'(cin);
      r[4] = ((u >> w) & 1) != 0;
    end else begin
      u = ua - ub;
      s = sa - sb;
      r[4] = (ua >= ub);
    end
    r[3:0] = 4'(u & mask);
    r[5] = (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
    return r;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, k, got, exp, $time);
    end
  endtask

  // Reference model: m_t counts cycles since an accepted start (0 = idle).
  int         m_t    [NI];
  logic [3:0] m_sum  [NI];
  logic [3:0] p_sum  [NI];
  logic       m_cout [NI];
  logic       m_ovf  [NI];
  logic       p_cout [NI];
  logic       p_ovf  [NI];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        m_t[k]    <= 0;
        m_sum[k]  <= '0;
        m_cout[k] <= 1'b0;
        m_ovf[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (start_v[k] && (m_t[k] == 0 || m_t[k] == wid(k) + 1)) begin
          {p_ovf[k], p_cout[k], p_sum[k]} <= ref_op(wid(k), a_v[k], b_v[k], cin_v[k], sub_v[k]);
          m_t[k] <= 1;
        end else if (m_t[k] >= 1 && m_t[k] <= wid(k)) begin
          m_t[k] <= m_t[k] + 1;
          if (m_t[k] == wid(k)) begin
            m_sum[k]  <= p_sum[k];
            m_cout[k] <= p_cout[k];
            m_ovf[k]  <= p_ovf[k];
          end
        end else begin
          m_t[k] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      chk("busy",     k, busy_o[k], (m_t[k] >= 1 && m_t[k] <= wid(k)));
      chk("done",     k, done_o[k], (m_t[k] == wid(k) + 1));
      chk("sum",      k, sum_o[k],  m_sum[k]);
      chk("cout",     k, cout_o[k], m_cout[k]);
      chk("overflow", k, ovf_o[k],  m_ovf[k]);
    end
  end

  task automatic run_op(input int k, input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic sub, input logic [3:0] es, input logic ec, input logic eo,
                        input bit repulse);
    int dones;
    @(negedge clk);
    a_v[k] = a; b_v[k] = b; cin_v[k] = cin; sub_v[k] = sub; start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    a_v[k] = ~a; b_v[k] = 4'($urandom); cin_v[k] = ~cin; sub_v[k] = ~sub;
    dones = 0;
    for (int n = 1; n <= wid(k) + 3; n++) begin
      if (done_o[k]) begin
        dones++;
        if (dones == 1) begin
          chk("latency", k, n, wid(k) + 1);
          chk("lit_sum", k, sum_o[k], es);
          chk("lit_cout", k, cout_o[k], ec);
          chk("lit_ovf", k, ovf_o[k], eo);
        end
      end
      start_v[k] = (repulse && n == 2);
      @(negedge clk);
    end
    chk("done_count", k, dones, 1);
    $display("op inst%0d a=%0d b=%0d cin=%0d sub=%0d -> sum=%0d cout=%0d ovf=%0d",
             k, a, b, cin, sub, sum_o[k], cout_o[k], ovf_o[k]);
  endtask

  initial begin
    int dones;
    logic a1, b1, c1;
    for (int k = 0; k < NI; k++) begin
      start_v[k] = 1'b0; sub_v[k] = 1'b0; cin_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk("rst_sum", k, sum_o[k], 0);
      chk("rst_busy", k, busy_o[k], 0);
      chk("rst_done", k, done_o[k], 0);
    end

    chk("model_3p5", 0, ref_op(4, 4'd3, 4'd5, 1'b0, 1'b0), 6'b1_0_1000);
    chk("model_8m1", 0, ref_op(4, 4'd8, 4'd1, 1'b0, 1'b1), 6'b1_1_0111);
    chk("model_5m7", 0, ref_op(4, 4'd5, 4'd7, 1'b1, 1'b1), 6'b0_0_1110);
    chk("model_fa111", 1, ref_op(1, 4'd1, 4'd1, 1'b1, 1'b0), 6'b0_1_0001);

    run_op(0, 4'd3,  4'd5, 1'b0, 1'b0, 4'd8,  1'b0, 1'b1, 1'b0);
    run_op(0, 4'd15, 4'd1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0);
    run_op(0, 4'd7,  4'd7, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0);
    run_op(0, 4'd5,  4'd7, 1'b1, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
    run_op(0, 4'd7,  4'd7, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0);
    run_op(0, 4'd8,  4'd1, 1'b1, 1'b1, 4'd7,  1'b1, 1'b1, 1'b0);
    run_op(0, 4'd6,  4'd9, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1);

    // Held start: one done every WIDTH+1 cycles.
    @(negedge clk);
    start_v[0] = 1'b1;
    dones = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done_o[0]) dones++;
      a_v[0] = 4'($urandom); b_v[0] = 4'($urandom);
      cin_v[0] = 1'($urandom); sub_v[0] = 1'($urandom);
    end
    start_v[0] = 1'b0;
    chk("held_dones", 0, dones, 3);
    $display("held start: %0d done pulses in 15 cycles", dones);
    repeat (6) @(negedge clk);

    // Asynchronous reset while bit 2 is being computed.
    run_op(0, 4'd9, 4'd4, 1'b0, 1'b0, 4'd13, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a_v[0] = 4'd2; b_v[0] = 4'd1; cin_v[0] = 1'b0; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sum", 0, sum_o[0], 0);
    chk("arst_busy", 0, busy_o[0], 0);
    chk("arst_done", 0, done_o[0], 0);
    @(posedge clk);
    #1 chk("arst_nodone", 0, done_o[0], 0);
    @(negedge clk);
    rst = 1'b0;
    $display("async reset applied mid-run");
    run_op(0, 4'd3, 4'd4, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);

    // WIDTH=1 full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; c1 = i[0];
      run_op(1, {3'b000, a1}, {3'b000, b1}, c1, 1'b0,
             {3'b000, a1 ^ b1 ^ c1}, (a1 & b1) | (a1 & c1) | (b1 & c1),
             (c1 & ~a1 & ~b1) | (~c1 & a1 & b1), 1'b0);
    end

    // Random traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        start_v[k] = ($urandom_range(0, 2) == 0);
        a_v[k] = 4'($urandom); b_v[k] = 4'($urandom);
        cin_v[k] = 1'($urandom); sub_v[k] = 1'($urandom);
      end
    end
    for (int k = 0; k < NI; k++) start_v[k] = 1'b0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
